// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - multi-cycle radix-2 restoring divider for MIPS DIV/DIVU
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             annul,
  input  logic             advance,
  output logic             stall,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo, abs_b;
  logic             q_neg, r_neg, div0;

  logic             accept, last_iter;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a_in, abs_b_in;
  logic [WIDTH:0]   trial, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, hi_fix, lo_fix;

  // Operand magnitudes, one restoring step, and the sign fix-up of the final step.
  always_comb begin
    accept    = (state == IDLE) & start & ~annul;
    last_iter = (state == CALC) & ~annul & (count == LAST);
    stall     = start & ~annul & (state != DONE);

    a_neg    = is_signed & dividend[WIDTH-1];
    b_neg    = is_signed & divisor[WIDTH-1];
    abs_a_in = a_neg ? -dividend : dividend;
    abs_b_in = b_neg ? -divisor : divisor;

    // Extra top bit keeps the shifted remainder exact when |b| exceeds 2^(W-1).
    trial   = {rem, quo[WIDTH-1]};
    diff    = trial - {1'b0, abs_b};
    ge      = ~diff[WIDTH];
    rem_nxt = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ge};

    // With a zero divisor the remainder ends as |a|, so re-signing it restores a.
    lo_fix = div0 ? '1 : (q_neg ? -quo_nxt : quo_nxt);
    hi_fix = r_neg ? -rem_nxt : rem_nxt;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; annul returns to IDLE from any state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start & ~annul) state_nxt = CALC;
      CALC:    if (annul) state_nxt = IDLE;
               else if (count == LAST) state_nxt = DONE;
      DONE:    if (advance | annul) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC, publish hi/lo on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      rem   <= '0;
      quo   <= '0;
      abs_b <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      div0  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      valid <= 1'b0;
    end else begin
      if (accept) begin
        rem   <= '0;
        quo   <= abs_a_in;
        abs_b <= abs_b_in;
        q_neg <= a_neg ^ b_neg;
        r_neg <= a_neg;
        div0  <= (divisor == '0);
        count <= '0;
      end else if ((state == CALC) && !annul) begin
        rem   <= rem_nxt;
        quo   <= quo_nxt;
        count <= count + CW'(1);
      end

      if (last_iter) begin
        hi    <= hi_fix;
        lo    <= lo_fix;
        valid <= 1'b1;
      end else if ((state == DONE) && (advance | annul)) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_div_radix2.sv
// tb/tb_div_radix2.sv - self-checking bench for div_radix2
module tb_div_radix2;

  logic        clk = 1'b0;
  logic        rst, start, is_signed, annul, advance;
  logic [31:0] dividend, divisor;
  logic        stall, valid;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];

  div_radix2 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .annul(annul), .advance(advance),
    .stall(stall), .valid(valid), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb_, q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa  = longint'($signed(a));
      sb_ = longint'($signed(b));
    end else begin
      sa  = longint'({32'd0, a});
      sb_ = longint'({32'd0, b});
    end
    q = sa / sb_;
    r = sa % sb_;
    return {r[31:0], q[31:0]};
  endfunction

  // Called at a falling edge: issues a divide, counts stall cycles, checks the DONE cycle.
  task automatic do_div(input string tag, input bit s, input logic [31:0] a,
                        input logic [31:0] b, input logic adv, input logic [63:0] exp);
    int n;
    logic [63:0] e;
    sb.push_back(exp);
    is_signed = s; dividend = a; divisor = b;
    start = 1'b1; annul = 1'b0; advance = adv;
    n = 0;
    #1;
    while (stall && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({tag, "_stall_cycles"}, 64'(n), 64'd33);
    chk({tag, "_valid"}, 64'(valid), 64'd1);
    if (sb.size() == 0) begin
      chk({tag, "_scoreboard_entry"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hilo"}, {hi, lo}, e);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    bit          rs;

    rst = 1'b1; start = 1'b0; is_signed = 1'b0; annul = 1'b0; advance = 1'b0;
    dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid", 64'(valid), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    chk("reset_stall_start0", 64'(stall), 64'd0);
    start = 1'b1;
    #1;
    chk("reset_stall_start1", 64'(stall), 64'd1);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Basic DIVU, then IDLE one cycle after DONE.
    @(negedge clk);
    do_div("divu_100_7", 0, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("idle_after_done_valid", 64'(valid), 64'd0);

    // Signed cases and divide by zero, issued back to back.
    @(negedge clk);
    do_div("div_m7_2", 1, 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    @(negedge clk);
    do_div("div_7_m2", 1, 32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD});
    @(negedge clk);
    do_div("div_ovf", 1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h0, 32'h8000_0000});
    @(negedge clk);
    do_div("divu_by0", 0, 32'h1234, 32'd0, 1'b1, {32'h1234, 32'hFFFF_FFFF});
    @(negedge clk);
    do_div("div_by0", 1, 32'hFFFF_FFF0, 32'd0, 1'b1, {32'hFFFF_FFF0, 32'hFFFF_FFFF});

    // Annul at T10, then re-issue at T11.
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1; advance = 1'b1;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    #1;
    chk("annul_stall", 64'(stall), 64'd0);
    @(negedge clk);
    annul = 1'b0;
    #1;
    chk("annul_valid", 64'(valid), 64'd0);
    do_div("reissue", 0, 32'd1000, 32'd3, 1'b1, {32'd1, 32'd333});

    // Hold in DONE with advance low while operands change.
    @(negedge clk);
    do_div("hold", 1, 32'hFFFF_FF9C, 32'd7, 1'b0, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dividend = $urandom;
      divisor  = $urandom;
      #1;
      chk($sformatf("hold%0d_stall", i), 64'(stall), 64'd0);
      chk($sformatf("hold%0d_valid", i), 64'(valid), 64'd1);
      chk($sformatf("hold%0d_hilo", i), {hi, lo}, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    end
    advance = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("hold_release_valid", 64'(valid), 64'd0);

    // Reset at T20 of an operation.
    @(negedge clk);
    is_signed = 1'b0; dividend = 32'd50000; divisor = 32'd7; start = 1'b1;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    #1;
    chk("midreset_valid", 64'(valid), 64'd0);
    chk("midreset_hilo", {hi, lo}, 64'd0);

    @(negedge clk);
    do_div("b2b_15_4", 0, 32'd15, 32'd4, 1'b1, {32'd3, 32'd3});
    @(negedge clk);
    do_div("b2b_9_3", 0, 32'd9, 32'd3, 1'b1, {32'd0, 32'd3});

    // Random operands against the reference model.
    for (int i = 0; i < 6; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (rs && (i % 3 == 0)) rb = -rb;
      @(negedge clk);
      do_div($sformatf("rand%0d", i), rs, ra, rb, 1'b1, model(rs, ra, rb));
    end

    @(negedge clk);
    start = 1'b0;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
